// File: rtl/tea_decrypt_if.sv
// Host-side handshake and data bundle for the iterative TEA decryption core.
interface tea_decrypt_if;
  logic         start;
  logic [31:0]  ct_v0;
  logic [31:0]  ct_v1;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [31:0]  pt_v0;
  logic [31:0]  pt_v1;
  logic [5:0]   round;

  modport master (
    output start, ct_v0, ct_v1, key,
    input  busy, done, pt_v0, pt_v1, round
  );

  modport slave (
    input  start, ct_v0, ct_v1, key,
    output busy, done, pt_v0, pt_v1, round
  );
endinterface

// File: rtl/tea_decrypt.sv
// Iterative TEA decryption: one full round per clock, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; results held, done pulses here for one cycle
//   RUN   | one decryption round per edge, ROUNDS edges in total
module tea_decrypt #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input logic          clk,
  input logic          reset_n,
  tea_decrypt_if.slave bus
);

  localparam logic [31:0] SUM_INIT   = DELTA * ROUNDS;
  localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] v0, v1, sum, k0, k1, k2, k3;
  logic [31:0] v0_nxt, v1_nxt, sum_nxt, k0_nxt, k1_nxt, k2_nxt, k3_nxt;
  logic [31:0] v0_rnd, v1_rnd;
  logic [31:0] pt_v0, pt_v1, pt_v0_nxt, pt_v1_nxt;
  logic [5:0]  round, round_nxt;
  logic        done, done_nxt;

  function automatic logic [31:0] tea_f(input logic [31:0] v, s, ka, kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // v0 is updated from the freshly computed v1 within the same round
  assign v1_rnd = v1 - tea_f(v0, sum, k2, k3);
  assign v0_rnd = v0 - tea_f(v1_rnd, sum, k0, k1);

  always_comb begin
    state_nxt = state;
    v0_nxt    = v0;
    v1_nxt    = v1;
    sum_nxt   = sum;
    k0_nxt    = k0;
    k1_nxt    = k1;
    k2_nxt    = k2;
    k3_nxt    = k3;
    round_nxt = round;
    pt_v0_nxt = pt_v0;
    pt_v1_nxt = pt_v1;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          v0_nxt    = bus.ct_v0;
          v1_nxt    = bus.ct_v1;
          k0_nxt    = bus.key[127:96];
          k1_nxt    = bus.key[95:64];
          k2_nxt    = bus.key[63:32];
          k3_nxt    = bus.key[31:0];
          sum_nxt   = SUM_INIT;
          round_nxt = 6'd0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        v0_nxt    = v0_rnd;
        v1_nxt    = v1_rnd;
        sum_nxt   = sum - DELTA;
        round_nxt = round + 6'd1;
        if (round == LAST_ROUND) begin
          pt_v0_nxt = v0_rnd;
          pt_v1_nxt = v1_rnd;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      k0    <= '0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
      round <= '0;
      pt_v0 <= '0;
      pt_v1 <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      v0    <= v0_nxt;
      v1    <= v1_nxt;
      sum   <= sum_nxt;
      k0    <= k0_nxt;
      k1    <= k1_nxt;
      k2    <= k2_nxt;
      k3    <= k3_nxt;
      round <= round_nxt;
      pt_v0 <= pt_v0_nxt;
      pt_v1 <= pt_v1_nxt;
      done  <= done_nxt;
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = done;
  assign bus.pt_v0 = pt_v0;
  assign bus.pt_v1 = pt_v1;
  assign bus.round = round;

endmodule

// File: tb/tb_tea_decrypt.sv
// Directed known-answer bench for tea_decrypt: latency, busy protection, back-to-back, abort.
module tb_tea_decrypt;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_err;

  tea_decrypt_if bus();

  tea_decrypt dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  localparam logic [127:0] KEY1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [31:0]  CT1_0 = 32'h5CF85E83, CT1_1 = 32'hE967E1FD;
  localparam logic [31:0]  PT1_0 = 32'h12345678, PT1_1 = 32'h9ABCDEF0;
  localparam logic [31:0]  CT2_0 = 32'h41EA3A0A, CT2_1 = 32'h94BAA940;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] c0, input logic [31:0] c1, input logic [127:0] k);
    @(negedge clk);
    bus.ct_v0 = c0;
    bus.ct_v1 = c1;
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // lat counts negedges after the accepting edge until done is seen
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    while (!bus.done && lat < 200) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_round(input logic [5:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.round != r && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_round_timeout", 64'(n < 100), 64'd1);
  endtask

  int lat, nbusy, ndone, cyc, d1, d2;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.ct_v0 = '0;
    bus.ct_v1 = '0;
    bus.key   = '0;

    // reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("idle_pt", {bus.pt_v0, bus.pt_v1}, 64'd0);
    chk("idle_round", 64'(bus.round), 64'd0);

    // known answer 2 (key=0)
    start_op(CT2_0, CT2_1, 128'd0);
    wait_done(lat, nbusy);
    chk("kat2_lat", 64'(lat), 64'd32);
    chk("kat2_pt", {bus.pt_v0, bus.pt_v1}, 64'd0);

    // known answer 1
    start_op(CT1_0, CT1_1, KEY1);
    wait_done(lat, nbusy);
    chk("kat1_lat", 64'(lat), 64'd32);
    chk("kat1_busy_cycles", 64'(nbusy), 64'd32);
    chk("kat1_pt", {bus.pt_v0, bus.pt_v1}, {PT1_0, PT1_1});
    chk("kat1_round", 64'(bus.round), 64'd32);
    chk("kat1_sum_zero", 64'(dut.sum), 64'd0);
    chk("kat1_busy_at_done", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("kat1_done_one_cycle", 64'(bus.done), 64'd0);
    chk("kat1_round_held", 64'(bus.round), 64'd32);

    // start while busy is ignored, inputs captured at start only
    start_op(CT1_0, CT1_1, KEY1);
    wait_round(6'd10);
    bus.ct_v0 = 32'hFFFFFFFF;
    bus.ct_v1 = 32'hFFFFFFFF;
    bus.key   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("busy_prot_pt", {bus.pt_v0, bus.pt_v1}, {PT1_0, PT1_1});
    chk("busy_prot_ndone", 64'(ndone), 64'd1);
    chk("busy_prot_idle", 64'(bus.busy), 64'd0);

    // abort mid-operation
    start_op(CT2_0, CT2_1, 128'd0);
    wait_round(6'd17);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_pt", {bus.pt_v0, bus.pt_v1}, 64'd0);
    chk("abort_round", 64'(bus.round), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("abort_no_activity", 64'(ndone), 64'd0);
    start_op(CT1_0, CT1_1, KEY1);
    wait_done(lat, nbusy);
    chk("abort_restart_lat", 64'(lat), 64'd32);
    chk("abort_restart_pt", {bus.pt_v0, bus.pt_v1}, {PT1_0, PT1_1});

    // back-to-back with start held high: vector 2 after vector 1
    start_op(CT2_0, CT2_1, 128'd0);
    wait_done(lat, nbusy);
    chk("b2b_pre_pt", {bus.pt_v0, bus.pt_v1}, 64'd0);
    @(negedge clk);
    bus.ct_v0 = CT1_0;
    bus.ct_v1 = CT1_1;
    bus.key   = KEY1;
    bus.start = 1'b1;
    cyc = 0;
    d1  = 0;
    d2  = 0;
    while (d2 == 0 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = cyc;
          chk("b2b_pt1", {bus.pt_v0, bus.pt_v1}, {PT1_0, PT1_1});
          bus.ct_v0 = CT2_0;
          bus.ct_v1 = CT2_1;
          bus.key   = 128'd0;
        end else begin
          d2 = cyc;
          bus.start = 1'b0;
        end
      end else if (d1 == 0 && cyc == 16) begin
        chk("b2b_pt_hold_first", {bus.pt_v0, bus.pt_v1}, 64'd0);
      end else if (d1 != 0 && cyc == d1 + 16) begin
        chk("b2b_pt_hold_second", {bus.pt_v0, bus.pt_v1}, {PT1_0, PT1_1});
      end
    end
    chk("b2b_first_done", 64'(d1), 64'd33);
    chk("b2b_spacing", 64'(d2 - d1), 64'd33);
    chk("b2b_pt2", {bus.pt_v0, bus.pt_v1}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
